// File: rtl/ysyx_23060208_dec_stage_if.sv
// ysyx_23060208_dec_stage_if: fetch, regfile, writeback and execute-side signals of the decode stage.
// slave is the decode stage itself; master is the surrounding pipeline.
interface ysyx_23060208_dec_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int IBUF_DEPTH = 4
);
    localparam int CW = $clog2(IBUF_DEPTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_inst;
    logic                  flush;
    logic [REG_WIDTH-1:0]  rf_raddr1;
    logic [REG_WIDTH-1:0]  rf_raddr2;
    logic [DATA_WIDTH-1:0] rf_rdata1;
    logic [DATA_WIDTH-1:0] rf_rdata2;
    logic                  wb_valid;
    logic [REG_WIDTH-1:0]  wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_inst;
    logic [DATA_WIDTH-1:0] out_src1;
    logic [DATA_WIDTH-1:0] out_src2;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [REG_WIDTH-1:0]  out_rd;
    logic                  out_rd_wen;
    logic [2:0]            out_cls;
    logic                  out_illegal;
    logic [CW-1:0]         ibuf_count;

    modport slave (
        input  in_valid, in_pc, in_inst, flush, rf_rdata1, rf_rdata2,
               wb_valid, wb_rd, wb_data, out_ready,
        output in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_inst,
               out_src1, out_src2, out_imm, out_rd, out_rd_wen, out_cls,
               out_illegal, ibuf_count
    );

    modport master (
        output in_valid, in_pc, in_inst, flush, rf_rdata1, rf_rdata2,
               wb_valid, wb_rd, wb_data, out_ready,
        input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_pc, out_inst,
               out_src1, out_src2, out_imm, out_rd, out_rd_wen, out_cls,
               out_illegal, ibuf_count
    );
endinterface

// File: rtl/ysyx_23060208_dec_stage.sv
// ysyx_23060208_dec_stage: instruction buffer, RV32I/E decoder and register busy scoreboard.
// Define YSYX_23060208_DEC_BYPASS_EN to let a same-cycle writeback clear hazards and feed operands.
module ysyx_23060208_dec_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int IBUF_DEPTH = 4
) (
    input logic                      clock,
    input logic                      reset,
    ysyx_23060208_dec_stage_if.slave bus
);
    localparam int PW   = $clog2(IBUF_DEPTH);
    localparam int CW   = $clog2(IBUF_DEPTH + 1);
    localparam int NREG = 1 << REG_WIDTH;

    typedef enum logic [2:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_UPPER, CLS_LOAD,
        CLS_STORE, CLS_BRANCH, CLS_JUMP, CLS_SYSTEM
    } cls_e;

    logic [DATA_WIDTH-1:0] pc_mem_q   [IBUF_DEPTH];
    logic [DATA_WIDTH-1:0] inst_mem_q [IBUF_DEPTH];
    logic [PW-1:0]         rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [NREG-1:0]       busy_q, busy_d, busy_eff, wb_mask, set_mask;
    logic                  push, pop, hazard;

    logic [31:0]           inst, imm;
    logic [6:0]            op;
    logic [2:0]            f3;
    logic [4:0]            rd_f, rs1_f, rs2_f;
    logic [REG_WIDTH-1:0]  rd, rs1, rs2;
    cls_e                  cls;
    logic                  opc_ok, wr, use1, use2, rv32e_bad, illegal, u1, u2, rd_wen;
    logic [DATA_WIDTH-1:0] raw1, raw2;

    assign inst  = inst_mem_q[rptr_q][31:0];
    assign op    = inst[6:0];
    assign f3    = inst[14:12];
    assign rd_f  = inst[11:7];
    assign rs1_f = inst[19:15];
    assign rs2_f = inst[24:20];
    assign rd    = rd_f[REG_WIDTH-1:0];
    assign rs1   = rs1_f[REG_WIDTH-1:0];
    assign rs2   = rs2_f[REG_WIDTH-1:0];

    always_comb begin
        cls    = CLS_ALU_R;
        opc_ok = 1'b1;
        wr     = 1'b0;
        use1   = 1'b0;
        use2   = 1'b0;
        imm    = '0;
        case (op)
            7'b0110011: begin use1 = 1'b1; use2 = 1'b1; wr = 1'b1; end
            7'b0010011: begin cls = CLS_ALU_I; use1 = 1'b1; wr = 1'b1; imm = {{20{inst[31]}}, inst[31:20]}; end
            7'b0110111,
            7'b0010111: begin cls = CLS_UPPER; wr = 1'b1; imm = {inst[31:12], 12'b0}; end
            7'b0000011: begin cls = CLS_LOAD; use1 = 1'b1; wr = 1'b1; imm = {{20{inst[31]}}, inst[31:20]}; end
            7'b0100011: begin cls = CLS_STORE; use1 = 1'b1; use2 = 1'b1; imm = {{20{inst[31]}}, inst[31:25], inst[11:7]}; end
            7'b1100011: begin
                cls  = CLS_BRANCH;
                use1 = 1'b1;
                use2 = 1'b1;
                imm  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b1101111: begin
                cls = CLS_JUMP;
                wr  = 1'b1;
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin cls = CLS_JUMP; use1 = 1'b1; wr = 1'b1; imm = {{20{inst[31]}}, inst[31:20]}; end
            // CSR ops read rs1 only for register forms (funct3 1..3); ecall/ebreak write nothing
            7'b1110011: begin
                cls  = CLS_SYSTEM;
                use1 = (f3 != 3'd0) && !f3[2];
                wr   = f3 != 3'd0;
                imm  = {{20{inst[31]}}, inst[31:20]};
            end
            default: opc_ok = 1'b0;
        endcase
    end

    assign rv32e_bad = (REG_WIDTH == 4) && ((use1 && rs1_f[4]) || (use2 && rs2_f[4]) || (wr && rd_f[4]));
    assign illegal   = !opc_ok || rv32e_bad;
    assign u1        = use1 && !illegal;
    assign u2        = use2 && !illegal;
    assign rd_wen    = wr && !illegal && (rd != '0);

    assign wb_mask  = bus.wb_valid ? (NREG'(1) << bus.wb_rd) : '0;
    assign set_mask = (pop && rd_wen) ? (NREG'(1) << rd) : '0;

`ifdef YSYX_23060208_DEC_BYPASS_EN
    assign busy_eff = busy_q & ~wb_mask;
    assign raw1     = (bus.wb_valid && bus.wb_rd == rs1) ? bus.wb_data : bus.rf_rdata1;
    assign raw2     = (bus.wb_valid && bus.wb_rd == rs2) ? bus.wb_data : bus.rf_rdata2;
`else
    assign busy_eff = busy_q;
    assign raw1     = bus.rf_rdata1;
    assign raw2     = bus.rf_rdata2;
`endif

    assign hazard = (u1 && rs1 != '0 && busy_eff[rs1]) ||
                    (u2 && rs2 != '0 && busy_eff[rs2]) ||
                    (rd_wen && busy_eff[rd]);

    assign bus.in_ready    = count_q < CW'(IBUF_DEPTH);
    assign bus.out_valid   = (count_q != '0) && !hazard;
    assign bus.ibuf_count  = count_q;
    assign bus.rf_raddr1   = rs1;
    assign bus.rf_raddr2   = rs2;
    assign bus.out_pc      = pc_mem_q[rptr_q];
    assign bus.out_inst    = inst_mem_q[rptr_q];
    assign bus.out_src1    = (u1 && rs1 != '0) ? raw1 : '0;
    assign bus.out_src2    = (u2 && rs2 != '0) ? raw2 : '0;
    assign bus.out_imm     = illegal ? '0 : DATA_WIDTH'($signed(imm));
    assign bus.out_rd      = rd;
    assign bus.out_rd_wen  = rd_wen;
    assign bus.out_cls     = cls;
    assign bus.out_illegal = illegal;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Flush overrides everything; a set beats a clear of the same busy bit
    always_comb begin
        count_d = bus.flush ? '0 : count_q + CW'(push) - CW'(pop);
        rptr_d  = bus.flush ? '0 : rptr_q + PW'(pop);
        wptr_d  = bus.flush ? '0 : wptr_q + PW'(push);
        busy_d  = bus.flush ? '0 : (busy_q & ~wb_mask) | set_mask;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            busy_q  <= '0;
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem_q[wptr_q]   <= bus.in_pc;
            inst_mem_q[wptr_q] <= bus.in_inst;
        end
    end
endmodule

// File: tb/tb_ysyx_23060208_dec_stage.sv
// tb_ysyx_23060208_dec_stage: directed and random stimulus against a queue/scoreboard reference model.
module tb_ysyx_23060208_dec_stage;
    localparam int DEPTH = 4;
`ifdef YSYX_23060208_DEC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc, inst, imm;
        logic [2:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic        ill, u1, u2, wen;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_23060208_dec_stage_if #(.DATA_WIDTH(32), .REG_WIDTH(5), .IBUF_DEPTH(DEPTH)) bus ();
    ysyx_23060208_dec_stage #(.DATA_WIDTH(32), .REG_WIDTH(5), .IBUF_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    logic [31:0] regs [32];
    assign bus.rf_rdata1 = regs[bus.rf_raddr1];
    assign bus.rf_rdata2 = regs[bus.rf_raddr2];
    always @(posedge clock) begin
        if (reset) for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h1000 + i;
        else if (bus.wb_valid && bus.wb_rd != 5'd0) regs[bus.wb_rd] <= bus.wb_data;
    end

    int errs = 0, checks = 0;
    exp_t q[$];
    int pend[$];
    logic [31:0] busy = '0;
    int wb_force = -1;
    logic [31:0] wb_fdata = '0;
    bit wb_auto = 1'b1;

    function automatic void chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h required %0h at %0t", n, got, want, $time);
        end
    endfunction

    // Reference decode straight from the ISA field definitions, immediates by arithmetic
    function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] inst);
        exp_t e;
        int im;
        int f3;
        e = '0;
        e.pc = pc; e.inst = inst; e.rd = inst[11:7]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
        f3 = int'(inst[14:12]);
        im = 0;
        case (inst[6:0])
            7'h33: begin e.cls = 0; e.u1 = 1; e.u2 = 1; e.wen = 1; end
            7'h13: begin e.cls = 1; e.u1 = 1; e.wen = 1; im = int'($signed(inst) >>> 20); end
            7'h37, 7'h17: begin e.cls = 2; e.wen = 1; im = int'(inst & 32'hFFFFF000); end
            7'h03: begin e.cls = 3; e.u1 = 1; e.wen = 1; im = int'($signed(inst) >>> 20); end
            7'h23: begin
                e.cls = 4; e.u1 = 1; e.u2 = 1;
                im = (inst[31] ? -2048 : 0) + int'(inst[30:25]) * 32 + int'(inst[11:7]);
            end
            7'h63: begin
                e.cls = 5; e.u1 = 1; e.u2 = 1;
                im = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
            end
            7'h6f: begin
                e.cls = 6; e.wen = 1;
                im = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
            end
            7'h67: begin e.cls = 6; e.u1 = 1; e.wen = 1; im = int'($signed(inst) >>> 20); end
            7'h73: begin
                e.cls = 7; e.u1 = (f3 >= 1 && f3 <= 3); e.wen = (f3 != 0);
                im = int'($signed(inst) >>> 20);
            end
            default: e.ill = 1;
        endcase
        e.imm = 32'(im);
        e.wen = e.wen && (e.rd != 0);
        return e;
    endfunction

    function automatic bit bz(input logic [4:0] r);
        return busy[r] && !(BYP && bus.wb_valid && bus.wb_rd == r);
    endfunction

    function automatic bit haz(input exp_t e);
        return (e.u1 && e.rs1 != 0 && bz(e.rs1)) || (e.u2 && e.rs2 != 0 && bz(e.rs2)) || (e.wen && bz(e.rd));
    endfunction

    function automatic logic [31:0] src_exp(input bit u, input logic [4:0] r);
        if (!u || r == 0) return 32'h0;
        if (BYP && bus.wb_valid && bus.wb_rd == r) return bus.wb_data;
        return regs[r];
    endfunction

    // Monitor: predicts handshakes each cycle, pops and compares on issue, then advances the model
    initial begin : mon
        int n, setr;
        bit v;
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                q.delete(); pend.delete(); busy = '0;
            end else begin
                n = q.size();
                v = (n != 0) ? !haz(q[0]) : 1'b0;
                chk("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
                chk("ibuf_count", 32'(bus.ibuf_count), 32'(n));
                chk("out_valid", 32'(bus.out_valid), 32'(v));
                if (bus.wb_valid)
                    for (int i = 0; i < pend.size(); i++)
                        if (pend[i] == int'(bus.wb_rd)) begin pend.delete(i); break; end
                if (bus.flush) begin
                    q.delete(); pend.delete(); busy = '0;
                end else begin
                    setr = -1;
                    if (v && bus.out_ready) begin
                        e = q.pop_front();
                        chk("out_pc", bus.out_pc, e.pc);
                        chk("out_inst", bus.out_inst, e.inst);
                        chk("out_imm", bus.out_imm, e.imm);
                        chk("out_cls", 32'(bus.out_cls), 32'(e.cls));
                        chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
                        chk("out_rd_wen", 32'(bus.out_rd_wen), 32'(e.wen));
                        chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
                        chk("out_src1", bus.out_src1, src_exp(e.u1, e.rs1));
                        chk("out_src2", bus.out_src2, src_exp(e.u2, e.rs2));
                        if (e.wen) begin setr = int'(e.rd); pend.push_back(int'(e.rd)); end
                    end
                    if (bus.wb_valid) busy[bus.wb_rd] = 1'b0;
                    if (setr >= 0) busy[setr] = 1'b1;
                    if (bus.in_valid && n < DEPTH) q.push_back(ref_decode(bus.in_pc, bus.in_inst));
                end
            end
        end
    end

    task automatic cyc(input bit iv, input logic [31:0] pc, input logic [31:0] inst, input bit ordy, input bit fl = 1'b0);
        @(negedge clock);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_inst   = inst;
        bus.out_ready = ordy;
        bus.flush     = fl;
        if (wb_force >= 0) begin
            bus.wb_valid = 1'b1; bus.wb_rd = 5'(wb_force); bus.wb_data = wb_fdata;
        end else if (wb_auto && pend.size() != 0 && $urandom_range(0, 2) == 0) begin
            int k;
            k = $urandom_range(0, pend.size() - 1);
            bus.wb_valid = 1'b1; bus.wb_rd = 5'(pend[k]); bus.wb_data = $urandom;
        end else begin
            bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input bit ordy);
        for (int t = 0; t < 40; t++) begin
            cyc(1'b1, pc, inst, ordy);
            if (bus.in_ready) return;
        end
        chk("push_timeout", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, ordy);
    endtask

    task automatic writeback(input int r, input logic [31:0] d);
        wb_force = r; wb_fdata = d;
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        wb_force = -1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] im);
        return {im, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] im);
        return {im, rs1, 3'b010, rd, 7'h03};
    endfunction
    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] im);
        return {im[12], im[10:5], rs2, rs1, 3'b000, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] x;
        logic [6:0] ops [12];
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h73, 7'h7f, 7'h0b};
        x = $urandom;
        x[6:0]   = ops[$urandom_range(0, 11)];
        x[11:7]  = 5'($urandom_range(0, 7));
        x[19:15] = 5'($urandom_range(0, 7));
        x[24:20] = 5'($urandom_range(0, 7));
        return x;
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.flush = 1'b0;
        bus.out_ready = 1'b0; bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        idle(3, 1'b0);
        reset = 1'b0;
        idle(2, 1'b0);

        // Fill with out_ready low, refuse a 5th push (also in a pop cycle), then drain in order
        wb_auto = 1'b0;
        for (int i = 1; i <= 4; i++) push(32'h100 + 4 * i, addi(5'(i), 5'd0, 12'(i)), 1'b0);
        cyc(1'b1, 32'h200, addi(5'd7, 5'd0, 12'd9), 1'b0);
        cyc(1'b1, 32'h200, addi(5'd7, 5'd0, 12'd9), 1'b1);
        idle(6, 1'b1);
        wb_auto = 1'b1;
        idle(30, 1'b1);

        // RAW: add waits on addi's writeback of x5
        wb_auto = 1'b0;
        push(32'h300, addi(5'd5, 5'd0, 12'd7), 1'b1);
        push(32'h304, add(5'd6, 5'd5, 5'd5), 1'b1);
        idle(4, 1'b1);
        writeback(5, 32'd7);
        idle(3, 1'b1);
        writeback(6, 32'd14);

        // RAW + WAW: lw x5 then addi x5,x5,1
        push(32'h400, lw(5'd5, 5'd2, 12'h10), 1'b1);
        push(32'h404, addi(5'd5, 5'd5, 12'd1), 1'b1);
        idle(4, 1'b1);
        writeback(5, 32'h55);
        idle(3, 1'b1);
        writeback(5, 32'h56);

        // Illegal word sets no busy bit: a reader of x31 must issue without stalling
        push(32'h500, 32'hFFFFFFFF, 1'b1);
        push(32'h504, addi(5'd1, 5'd31, 12'd1), 1'b1);
        idle(3, 1'b1);
        writeback(1, 32'h11);

        // Branch immediate -4
        push(32'h80000010, beq(5'd1, 5'd2, 13'h1FFC), 1'b1);
        idle(3, 1'b1);

        // Flush with 3 buffered entries and x5 busy
        push(32'h600, addi(5'd5, 5'd0, 12'd1), 1'b1);
        idle(1, 1'b1);
        push(32'h604, add(5'd7, 5'd5, 5'd5), 1'b0);
        push(32'h608, addi(5'd1, 5'd0, 12'd2), 1'b0);
        push(32'h60c, addi(5'd2, 5'd0, 12'd3), 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        idle(1, 1'b0);
        push(32'h610, add(5'd8, 5'd5, 5'd5), 1'b1);
        idle(2, 1'b1);
        writeback(8, 32'h88);
        wb_auto = 1'b1;
        idle(20, 1'b1);

        // Random traffic with occasional flush and a mid-run reset
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom & ~32'h3, rnd_inst(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 99) == 0);
            reset = (i >= 700 && i < 702);
        end
        for (int t = 0; t < 300 && q.size() != 0; t++) cyc(1'b0, 32'h0, 32'h0, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);
        idle(2, 1'b1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ysyx_23060208_dec_stage.md
YSYX_23060208_DEC_STAGE -- requirements
Module: ysyx_23060208_dec_stage

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the register/PC/instruction width.
REQ-002 The block SHALL have parameter REG_WIDTH, default 5, the register index width; 5 selects RV32I, 4 selects RV32E.
REQ-003 The block SHALL have parameter IBUF_DEPTH, default 4, the instruction buffer depth; power of two, at least 2.
REQ-004 The block SHALL have port clock  in  1  clock; all state on rising edge.
REQ-005 The block SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have ports in_valid in 1, in_ready out 1, in_pc in DATA_WIDTH, in_inst in DATA_WIDTH: the fetch-side handshake and payload.
REQ-007 The block SHALL have port flush  in  1  discards all buffered and pending state.
REQ-008 The block SHALL have ports rf_raddr1/rf_raddr2 out REG_WIDTH and rf_rdata1/rf_rdata2 in DATA_WIDTH: the external regfile read ports, with combinational read.
REQ-009 The block SHALL have ports wb_valid in 1, wb_rd in REG_WIDTH, wb_data in DATA_WIDTH: the writeback notification.
REQ-010 The block SHALL have ports out_valid out 1 and out_ready in 1: the execute-side handshake.
REQ-011 The block SHALL have ports out_pc, out_inst, out_src1, out_src2, out_imm, each out DATA_WIDTH.
REQ-012 The block SHALL have ports out_rd out REG_WIDTH, out_rd_wen out 1, out_cls out 3, out_illegal out 1, ibuf_count out clog2(IBUF_DEPTH+1).

Function
REQ-013 The buffer SHALL be a FIFO of {pc,inst} entries; in_ready SHALL be (count < IBUF_DEPTH), independent of out_ready, so a full buffer accepts no push even in a pop cycle.
REQ-014 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready; simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo IBUF_DEPTH.
REQ-015 The head entry SHALL be decoded combinationally; an entry pushed at edge N SHALL be presentable on out_* after edge N, one cycle of latency.
REQ-016 out_cls SHALL encode 0 ALU_R (0110011), 1 ALU_I (0010011), 2 UPPER (lui/auipc), 3 LOAD, 4 STORE, 5 BRANCH, 6 JUMP (jal/jalr), 7 SYSTEM (1110011).
REQ-017 out_illegal SHALL be 1 for any other opcode, or when REG_WIDTH==4 and any used register field has bit 4 set; illegal entries SHALL issue with out_rd_wen=0 and set no busy bit.
REQ-018 out_imm SHALL be the sign-extended I/S/B/U/J immediate selected by class, and 0 for ALU_R and illegal.
REQ-019 out_rd_wen SHALL be 1 for ALU_R, ALU_I, UPPER, LOAD, JUMP, and SYSTEM with funct3!=0, and only when rd!=0.
REQ-020 rs1 SHALL count as used for ALU_R, ALU_I, LOAD, STORE, BRANCH, jalr, and SYSTEM with funct3 in {1,2,3}; rs2 SHALL count as used for ALU_R, STORE, BRANCH.
REQ-021 rf_raddr1/2 SHALL be head rs1/rs2; out_src1/2 SHALL be 0 when the register is unused or x0, and rf_rdata otherwise, subject to REQ-031.
REQ-022 A scoreboard of 2^REG_WIDTH busy bits SHALL be kept; issue with out_rd_wen SHALL set busy[rd], and wb_valid SHALL clear busy[wb_rd].
REQ-023 A hazard SHALL exist if used rs1 or rs2 (non-zero) is busy, or if out_rd_wen and busy[rd] is set (WAW).
REQ-024 out_valid SHALL be (count!=0) && !hazard; once asserted it SHALL stay asserted with stable payload until a pop or a flush.
REQ-025 A set and a clear of the same busy bit in the same cycle SHALL leave the bit set.
REQ-026 flush SHALL empty the FIFO and clear all busy bits at the edge, overriding push, pop and wb that cycle; in_ready SHALL be 1 the next cycle.

Reset
REQ-027 Reset SHALL give count=0, read/write pointers 0, all busy bits 0.
REQ-028 After reset, out_valid SHALL be 0, in_ready 1, ibuf_count 0.
REQ-029 Reset asserted mid-operation SHALL discard buffered entries without issuing them.

Configuration
REQ-030 Macro YSYX_23060208_DEC_BYPASS_EN SHALL select writeback bypass.
REQ-031 With YSYX_23060208_DEC_BYPASS_EN defined, a register with wb_valid && wb_rd==r SHALL count as not busy this cycle, and out_src SHALL take wb_data for that register.
REQ-032 Without YSYX_23060208_DEC_BYPASS_EN, the hazard SHALL persist until the cycle after writeback, and out_src SHALL come from rf_rdata only.

Verification
REQ-033 The bench SHALL push 4 entries with out_ready=0 -> in_ready=0 and ibuf_count=4; a 5th push SHALL be refused; draining SHALL produce the entries in order.
REQ-034 The bench SHALL issue addi x5,x0,7 then add x6,x5,x5 -> add held with out_valid=0 until wb_valid with wb_rd=5; the add SHALL issue the same cycle with bypass, or one cycle later without.
REQ-035 The bench SHALL issue lw x5 and then addi x5,x5,1 -> the WAW/RAW stall SHALL hold until wb_rd=5.
REQ-036 The bench SHALL send inst 0xFFFFFFFF -> out_illegal=1, out_rd_wen=0, and no busy bit set.
REQ-037 The bench SHALL assert flush with 3 buffered entries and busy[5] set -> next cycle ibuf_count=0, out_valid=0, and busy cleared.
REQ-038 The bench SHALL present beq with imm=-4 at pc=0x80000010 -> out_cls=5, out_imm=0xFFFFFFFC, out_rd_wen=0.
